// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the HEX character rotator.
package hex_disp_pkg;

    // 2-bit character codes understood by the downstream segment decoder
    localparam logic [1:0] CH_D = 2'b00;
    localparam logic [1:0] CH_E = 2'b01;
    localparam logic [1:0] CH_1 = 2'b10;
    localparam logic [1:0] CH_0 = 2'b11;

    localparam int unsigned CHAR_W = 2;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle on which it wraps.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_wrap    = i_en && w_at_last;

    // Count while enabled; hold (not clear) while disabled so a resume finishes the period
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_char_rotator.sv
// Rotating word of 2-bit character codes for the HEX displays, with run/stop,
// single-step, direction and parallel load.
module hex_char_rotator
    import hex_disp_pkg::*;
#(
    parameter int unsigned             TICK_DIV  = 50_000_000,
    parameter int unsigned             NUM_DISP  = 4,
    parameter logic [2*NUM_DISP-1:0]   INIT_WORD = (2*NUM_DISP)'(8'h1B)
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       run,
    input  logic                       dir,
    input  logic                       step,
    input  logic                       load,
    input  logic [2*NUM_DISP-1:0]      load_word,
    output logic [2*NUM_DISP-1:0]      char_out,
    output logic                       tick,
    output logic [2:0]                 shift_cnt
);

    localparam int unsigned W = CHAR_W * NUM_DISP;
    localparam logic [2:0]  SC_LAST = 3'(NUM_DISP - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_char;
    logic [W-1:0]  w_char_nxt;
    logic [2:0]    r_shift;
    logic [2:0]    w_shift_nxt;
    logic          r_tick;
    logic          w_wrap;
    logic          w_rot;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .i_en     (r_state == ST_RUN),
        .i_clr    (load),
        .o_wrap   (w_wrap)
    );

    // A load swallows any rotation requested on the same edge
    assign w_rot = !load && (w_wrap || ((r_state == ST_STOP) && step));

    // Next-state for FSM, character word and rotation count
    always_comb begin
        w_state_nxt = run ? ST_RUN : ST_STOP;
        w_char_nxt  = r_char;
        w_shift_nxt = r_shift;
        if (load) begin
            w_char_nxt  = load_word;
            w_shift_nxt = '0;
        end else if (w_rot) begin
            if (!dir) begin
                // Left: every code moves one position toward the MSBs
                w_char_nxt  = {r_char[W-CHAR_W-1:0], r_char[W-1:W-CHAR_W]};
                w_shift_nxt = (r_shift == SC_LAST) ? 3'd0 : r_shift + 3'd1;
            end else begin
                w_char_nxt  = {r_char[CHAR_W-1:0], r_char[W-1:CHAR_W]};
                w_shift_nxt = (r_shift == 3'd0) ? SC_LAST : r_shift - 3'd1;
            end
        end
    end

    // State registers; RESET overrides everything
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= ST_STOP;
            r_char  <= INIT_WORD;
            r_shift <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_char  <= w_char_nxt;
            r_shift <= w_shift_nxt;
            r_tick  <= w_rot;
        end
    end

    assign char_out  = r_char;
    assign tick      = r_tick;
    assign shift_cnt = r_shift;

endmodule
